// File: rtl/ldiv_rq.sv
// ldiv_rq -- result queue and issue-credit controller for the pipelined
// long divider.
//
// The divider cannot be stalled. Its results are buffered in a circular FIFO
// and presented on a ready/valid port. Upstream issue credit is granted only
// while (divides in flight + queued results) < DEPTH. That guarantees every
// result has a free slot when it arrives.
//
// Optional feature: define LDIV_RQ_DIVZ_EN to carry a divide-by-zero flag
// alongside each result. The flag travels through a LATENCY-stage delay line
// and is stored as one extra FIFO bit. Without the macro, m_divz is tied to 0
// and issue_divz_in is ignored.
//
// Ports:
//   clk, resetb          clock, asynchronous active-low reset
//   issue_in             upstream starts a divide this cycle
//   issue_divz_in        the issued divide has a zero denominator
//   can_issue            credit: upstream may issue only while high
//   div_valid_in         divider result valid
//   div_quotient_in      divider quotient
//   div_remainder_in     divider remainder
//   m_valid / m_ready    head entry handshake
//   m_quotient           head quotient
//   m_remainder          head remainder
//   m_divz               head divide-by-zero flag
//   count                FIFO occupancy
//   overflow             sticky error: dropped push or credit protocol violation
module ldiv_rq #(
   parameter int NUMERATOR_WIDTH = 24,
   parameter int QUOTIENT_WIDTH  = 24,
   parameter int DEPTH           = 16
) (
   input  logic                            clk,
   input  logic                            resetb,
   input  logic                            issue_in,
   input  logic                            issue_divz_in,
   output logic                            can_issue,
   input  logic                            div_valid_in,
   input  logic [QUOTIENT_WIDTH-1:0]       div_quotient_in,
   input  logic [NUMERATOR_WIDTH-1:0]      div_remainder_in,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [QUOTIENT_WIDTH-1:0]       m_quotient,
   output logic [NUMERATOR_WIDTH-1:0]      m_remainder,
   output logic                            m_divz,
   output logic [$clog2(DEPTH+1)-1:0]      count,
   output logic                            overflow
);

   localparam int LATENCY = NUMERATOR_WIDTH + 1;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
`ifdef LDIV_RQ_DIVZ_EN
   localparam int ENTRY_W = QUOTIENT_WIDTH + NUMERATOR_WIDTH + 1;
`else
   localparam int ENTRY_W = QUOTIENT_WIDTH + NUMERATOR_WIDTH;
`endif

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_inflight;
   logic               r_overflow;

   logic               w_pop;
   logic               w_full;
   logic               w_push;
   logic               w_drop;
   logic [CNT_W:0]     w_credit_sum;
   logic               w_issue_err;
   logic               w_ret_err;
   logic [CNT_W-1:0]   w_inflight_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [ENTRY_W-1:0] w_wr_data;
   logic [ENTRY_W-1:0] w_head;

   assign w_pop  = (r_count != '0) && m_ready;
   assign w_full = (r_count == CNT_W'(DEPTH));
   // A push at full still fits when the head leaves in the same cycle.
   assign w_push = div_valid_in && (!w_full || w_pop);
   assign w_drop = div_valid_in && w_full && !w_pop;

   // Credit is derived from registers only, so it never depends on m_ready.
   assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_count};
   assign can_issue    = (w_credit_sum < (CNT_W+1)'(DEPTH));
   assign w_issue_err  = issue_in && !can_issue;
   assign w_ret_err    = div_valid_in && (r_inflight == '0);

   always_comb begin
      w_inflight_nxt = r_inflight;
      // Saturate at both ends instead of wrapping; the error is flagged separately.
      if (issue_in && !div_valid_in) begin
         if (!(&r_inflight)) w_inflight_nxt = r_inflight + CNT_W'(1);
      end else if (!issue_in && div_valid_in) begin
         if (r_inflight != '0) w_inflight_nxt = r_inflight - CNT_W'(1);
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

`ifdef LDIV_RQ_DIVZ_EN
   logic [LATENCY-1:0] r_dz_line;

   // Stage LATENCY-1 holds the flag of the divide whose result arrives now.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) r_dz_line <= '0;
      else         r_dz_line <= {r_dz_line[LATENCY-2:0], issue_in & issue_divz_in};
   end

   assign w_wr_data = {div_quotient_in, div_remainder_in, r_dz_line[LATENCY-1]};
`else
   logic w_unused_divz;
   assign w_unused_divz = issue_divz_in;
   assign w_wr_data     = {div_quotient_in, div_remainder_in};
`endif

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count    <= w_count_nxt;
         r_inflight <= w_inflight_nxt;
         if (w_drop || w_issue_err || w_ret_err) r_overflow <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_wr_data;
   end

   assign w_head      = r_mem[r_rd_ptr];
   assign m_valid     = (r_count != '0);
   assign m_quotient  = w_head[ENTRY_W-1 -: QUOTIENT_WIDTH];
   assign m_remainder = w_head[ENTRY_W-QUOTIENT_WIDTH-1 -: NUMERATOR_WIDTH];
`ifdef LDIV_RQ_DIVZ_EN
   assign m_divz      = m_valid & w_head[0];
`else
   assign m_divz      = 1'b0;
`endif
   assign count       = r_count;
   assign overflow    = r_overflow;

endmodule
